// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register peripheral.
// Optional read path is enabled by defining SPI_READBACK_EN.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;
    localparam int NUM_REGS   = 5;

    localparam logic [6:0] ADDR_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with 1-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI Mode-0 register file: oversampled frame decoder plus five 8-bit control registers.
// Define SPI_READBACK_EN to service read frames on cipo; otherwise cipo is tied low.
module spi_reg_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4,
    parameter int FRAME_BITS  = spi_reg_pkg::FRAME_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sclk,
    input  logic                copi,
    input  logic                ncs,
    output logic                cipo,
    output logic [7:0]          en_reg_out_7_0,
    output logic [7:0]          en_reg_out_15_8,
    output logic [7:0]          en_reg_pwm_7_0,
    output logic [7:0]          en_reg_pwm_15_8,
    output logic [7:0]          pwm_duty_cycle,
    output spi_reg_pkg::state_e dbg_state_o
);
    import spi_reg_pkg::*;

    localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d_i(copi),
        .level_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall)
    );
    // ncs idles high, so its synchronizer resets high to avoid a spurious edge.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d_i(ncs),
        .level_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [FRAME_BITS-1:0]  shift_d;
    logic [7:0]             regs_q [NUM_REGS];

    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
    logic       wr_ok;

    assign shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
    assign rw      = shift_q[FRAME_BITS-1];
    assign addr    = shift_q[FRAME_BITS-2 -: 7];
    assign data    = shift_q[7:0];
    assign wr_ok   = (cnt_q == CNT_FULL) && rw && (int'(addr) <= MAX_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ncs_fall) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        shift_q <= '0;
                    end
                end
                SHIFT: begin
                    // A frame end in the same cycle as an sclk edge drops that edge.
                    if (ncs_rise) begin
                        state_q <= COMMIT;
                    end else if (sclk_rise) begin
                        shift_q <= shift_d;
                        if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (wr_ok && (addr == 7'(i))) regs_q[i] <= data;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = regs_q[ADDR_OUT_7_0];
    assign en_reg_out_15_8 = regs_q[ADDR_OUT_15_8];
    assign en_reg_pwm_7_0  = regs_q[ADDR_PWM_7_0];
    assign en_reg_pwm_15_8 = regs_q[ADDR_PWM_15_8];
    assign pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY];
    assign dbg_state_o     = state_q;

`ifdef SPI_READBACK_EN
    logic [7:0] tx_q;
    logic [7:0] rd_data;
    logic [6:0] rd_addr;

    // After 8 bits the R/W flag sits at bit 7 and the address in bits 6:0 of shift_d.
    assign rd_addr = shift_d[6:0];

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((rd_addr == 7'(i)) && (int'(rd_addr) <= MAX_ADDR)) rd_data = regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= 8'h00;
        end else if (state_q == SHIFT) begin
            if (ncs_rise) begin
                tx_q <= 8'h00;
            end else if (sclk_rise && (cnt_q == CNT_W'(7)) && !shift_d[7]) begin
                tx_q <= rd_data;
            end else if (sclk_fall && (cnt_q >= CNT_W'(9)) && (cnt_q <= CNT_FULL)) begin
                tx_q <= {tx_q[6:0], 1'b0};
            end
        end else begin
            tx_q <= 8'h00;
        end
    end

    assign cipo = tx_q[7];

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, copi_rise, copi_fall, ncs_lvl};
`else
    assign cipo = 1'b0;

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall, ncs_lvl};
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Self-checking bench for spi_reg_peripheral: directed frames then randomized frames vs a register model.
module tb_spi_reg_peripheral;
    import spi_reg_pkg::*;

    localparam int SYNC = 2;
    localparam int HALF = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic copi = 1'b0;
    logic ncs = 1'b1;
    logic cipo;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    state_e dbg_state;

    spi_reg_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(4)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] model [5];
    logic [7:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        logic [7:0] got [5];
        got[0] = en_reg_out_7_0;
        got[1] = en_reg_out_15_8;
        got[2] = en_reg_pwm_7_0;
        got[3] = en_reg_pwm_15_8;
        got[4] = pwm_duty_cycle;
        for (int i = 0; i < 5; i++) exp_q.push_back(model[i]);
        for (int i = 0; i < 5; i++) check_eq($sformatf("%s_reg%0d", tag, i), got[i], exp_q.pop_front());
    endtask

    // Drives nbits bits MSB-first from bits[nbits-1:0]; captures cipo before rising edges 9..16.
    task automatic spi_frame(input logic [16:0] bits, input int nbits, output logic [7:0] miso);
        miso = 8'h00;
        @(negedge clk);
        ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            copi = bits[nbits-1-i];
            repeat (HALF) @(negedge clk);
            if (i >= 8 && i < 16) miso = {miso[6:0], cipo};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        ncs = 1'b1;
        copi = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
    endtask

    task automatic do_frame(input string tag, input logic rw, input logic [6:0] addr,
                            input logic [7:0] data, input int nbits, input logic extra);
        logic [15:0] word;
        logic [16:0] bits;
        logic [7:0]  miso;
        logic [7:0]  rd_exp;
        word = {rw, addr, data};
        if (nbits == 17)      bits = {word, extra};
        else if (nbits == 15) bits = {2'b00, word[15:1]};
        else                  bits = {1'b0, word};
        rd_exp = (int'(addr) <= 4) ? model[int'(addr)] : 8'h00;
        spi_frame(bits, nbits, miso);
        if (nbits == 16 && rw && int'(addr) <= 4) model[int'(addr)] = data;
`ifdef SPI_READBACK_EN
        if (nbits >= 16 && !rw) check_eq({tag, "_readback"}, miso, rd_exp);
`else
        if (nbits >= 16 && !rw) check_eq({tag, "_cipo_during"}, miso, 8'h00);
`endif
        check_regs(tag);
        check_eq({tag, "_cipo_idle"}, {7'b0, cipo}, 8'h00);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        repeat (4) @(negedge clk);
        check_regs("reset");
        check_eq("reset_state", {6'b0, dbg_state}, {6'b0, IDLE});
        check_eq("reset_cipo", {7'b0, cipo}, 8'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        do_frame("duty80", 1'b1, 7'h04, 8'h80, 16, 1'b0);
        do_frame("out_ff", 1'b1, 7'h00, 8'hFF, 16, 1'b0);
        do_frame("pwm_0f", 1'b1, 7'h02, 8'h0F, 16, 1'b0);
        do_frame("bad_05", 1'b1, 7'h05, 8'hAA, 16, 1'b0);
        do_frame("bad_7f", 1'b1, 7'h7F, 8'h55, 16, 1'b0);
        do_frame("short",  1'b1, 7'h04, 8'h11, 15, 1'b0);
        do_frame("long",   1'b1, 7'h04, 8'h22, 17, 1'b1);

        // Reset in the middle of a frame after 9 bits.
        @(negedge clk);
        ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            copi = 1'($urandom_range(0, 1));
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        ncs = 1'b1;
        copi = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        check_regs("midreset");
        check_eq("midreset_state", {6'b0, dbg_state}, {6'b0, IDLE});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        do_frame("post_rst", 1'b1, 7'h01, 8'h5A, 16, 1'b0);

        do_frame("wr_c3", 1'b1, 7'h03, 8'hC3, 16, 1'b0);
        do_frame("rd_03", 1'b0, 7'h03, 8'($urandom_range(0, 255)), 16, 1'b0);
        do_frame("rd_7f", 1'b0, 7'h7F, 8'h00, 16, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int sel;
            int nb;
            logic [6:0] a;
            sel = $urandom_range(0, 9);
            nb = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
            a = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
            do_frame($sformatf("rnd%0d", n), ($urandom_range(0, 3) != 0), a,
                     8'($urandom_range(0, 255)), nb, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
